axi4_lite_write_arbiter: RTL
============================

# axi4_lite_write_arbiter

Two-master AXI4-Lite write-channel arbiter. Shares one downstream write slave (AW/W/B) between requester M0 (LSU store path) and requester M1 (secondary writer, e.g. debug/DMA). It grants one complete write transaction at a time: address, data, then response. It sits between the core's write masters and the AXI4-Lite write slave port.

## Interface
Parameters:
- ADDR_W, default 64, address width.
- DATA_W, default 64, data width.
- STRB_W, default 8, write-strobe width.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- Mx_AW_ADDR  in  ADDR_W  write address, for x = 0, 1.
- Mx_AW_VALID  in  1  address valid; this is the arbitration request.
- Mx_AW_READY  out  1  address accepted.
- Mx_W_DATA  in  DATA_W  write data.
- Mx_W_STRB  in  STRB_W  byte strobes.
- Mx_W_VALID  in  1  data valid.
- Mx_W_READY  out  1  data accepted.
- Mx_B_RESP  out  2  write response.
- Mx_B_VALID  out  1  response valid.
- Mx_B_READY  in  1  response accepted.
- S_AW_ADDR / S_AW_VALID  out  ADDR_W / 1  to slave.
- S_AW_READY  in  1  from slave.
- S_W_DATA / S_W_STRB / S_W_VALID  out  DATA_W / STRB_W / 1  to slave.
- S_W_READY  in  1  from slave.
- S_B_RESP / S_B_VALID  in  2 / 1  from slave.
- S_B_READY  out  1  to slave.
- GRANT  out  2  one-hot owner: bit0 = M0, bit1 = M1, 00 = none.
- BUSY  out  1  high when the state is not IDLE.

## Operation
State machine: IDLE, ADDR, RESP.
- IDLE
  - GRANT=00.
  - If any Mx_AW_VALID is high, register the winner into GRANT and move to ADDR.
  - Winner is chosen by the priority rule (see Configuration).
  - W_VALID alone does not request.
- ADDR
  - Granted master's AW/W fields are muxed combinationally to S_AW_* and S_W_*.
  - S_AW_VALID = Mg_AW_VALID & ~aw_done. S_W_VALID = Mg_W_VALID & ~w_done.
  - Mg_AW_READY = S_AW_READY & ~aw_done. Mg_W_READY likewise.
  - aw_done / w_done are set on the respective handshake. They may complete in any order or in the same cycle.
  - When both are done (including same-cycle completion of the last one), clear both flags and move to RESP.
- RESP
  - S_B_RESP and S_B_VALID are routed to the granted master. S_B_READY = Mg_B_READY.
  - On the S_B_VALID & S_B_READY handshake: record the granted index as last_grant, clear GRANT, move to IDLE.
- Non-granted master outputs: all READY and B_VALID are 0, B_RESP is 00.
- With no grant, S_* address, data and strobe outputs are driven 0.
- Slave responses arriving in IDLE or ADDR are not forwarded. S_B_READY is 0 outside RESP.

## Timing
- Reset values:
  - State IDLE, GRANT=00, BUSY=0.
  - aw_done = w_done = 0, last_grant = M1, so M0 wins the first tie.
  - Every VALID/READY output is 0; S_AW_ADDR, S_W_DATA and S_W_STRB are 0.
- Grant latency:
  - A request seen in IDLE at cycle N gives GRANT and S_AW_VALID at cycle N+1.
  - Minimum transaction is 4 cycles: IDLE sample, ADDR (AW+W same cycle), RESP (B same cycle), back in IDLE.
- Grant is held for the entire transaction. A higher-priority request arriving mid-transaction has no effect until IDLE.
- Ready-before-valid is allowed: a slave READY with no granted VALID causes no handshake.
- A master that drops AW_VALID before the handshake violates AXI. Behaviour is undefined; no recovery is required.
- Reset asserted in any state: next cycle all outputs are at their reset values, in-flight flags are cleared, and the transaction is abandoned.
- GRANT and BUSY are registered. All datapath muxing is combinational from the registered GRANT, with no added latency.

## Configuration
- AXI_WARB_ROUND_ROBIN_EN defined:
  - Round robin. On a simultaneous request, the master not equal to last_grant wins.
  - A single requester always wins.
- Macro undefined:
  - Fixed priority; M0 always wins a tie.
  - last_grant is still maintained but ignored.

## Test plan
- Single M0 write, addr 0x8000_0010, data 0xDEAD_BEEF, strb 0xFF; slave READY on first valid, B_RESP 00 next cycle.
  - Expect S_AW_VALID at cycle 1, M0_B_VALID with RESP 00 at cycle 2, IDLE at cycle 3, M1 outputs all 0.
- W handshake first, AW accepted 3 cycles later.
  - Expect S_W_VALID to drop after its handshake, M0_W_READY pulsed once, RESP entered only after the AW handshake.
- M0 and M1 request in the same cycle, repeatedly, over 4 transactions.
  - With the macro defined: grant order M0, M1, M0, M1.
  - Undefined: M0, M0, M0, M0 while M0 keeps requesting.
- M1 granted; M0 requests during ADDR; slave returns B_RESP 10 with B_READY stalled 2 cycles.
  - Expect M1_B_RESP = 10 held stable, M0 granted only after return to IDLE.
- RST asserted during RESP with S_B_VALID high.
  - Next cycle: GRANT=00, BUSY=0, S_B_READY=0, all master READY/VALID 0.
  - A fresh M1 request then completes normally.

Source files
------------

// File: rtl/axi4_lite_write_arbiter_if.sv
// AXI4-Lite write channel bundle (AW/W/B) used between requesters, the arbiter and the shared slave.
interface axi4_lite_write_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int STRB_W = 8
);
    logic [ADDR_W-1:0] AW_ADDR;
    logic              AW_VALID;
    logic              AW_READY;
    logic [DATA_W-1:0] W_DATA;
    logic [STRB_W-1:0] W_STRB;
    logic              W_VALID;
    logic              W_READY;
    logic [1:0]        B_RESP;
    logic              B_VALID;
    logic              B_READY;

    modport master (
        output AW_ADDR, AW_VALID, W_DATA, W_STRB, W_VALID, B_READY,
        input  AW_READY, W_READY, B_RESP, B_VALID
    );

    modport slave (
        input  AW_ADDR, AW_VALID, W_DATA, W_STRB, W_VALID, B_READY,
        output AW_READY, W_READY, B_RESP, B_VALID
    );
endinterface

// File: rtl/axi4_lite_write_arbiter.sv
// Two-master AXI4-Lite write arbiter: one full AW/W/B transaction granted at a time.
// Define AXI_WARB_ROUND_ROBIN_EN for round-robin tie breaking; default is fixed priority to M0.
module axi4_lite_write_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int STRB_W = 8
) (
    input  logic                        CLK,
    input  logic                        RST,
    axi4_lite_write_arbiter_if.slave    M0,
    axi4_lite_write_arbiter_if.slave    M1,
    axi4_lite_write_arbiter_if.master   S,
    output logic [1:0]                  GRANT,
    output logic                        BUSY
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              busy_q;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              last_grant_q, last_grant_d;  // 0 = M0, 1 = M1
    logic              pick_m1;
    logic              sel0, sel1, in_addr, in_resp;
    logic              mg_aw_valid, mg_w_valid, mg_b_ready;
    logic              s_aw_valid, s_w_valid, s_b_ready;
    logic              aw_hs, w_hs, b_hs;
    logic [ADDR_W-1:0] aw_addr_mux;
    logic [DATA_W-1:0] w_data_mux;
    logic [STRB_W-1:0] w_strb_mux;

    assign sel0    = grant_q[0];
    assign sel1    = grant_q[1];
    assign in_addr = (state_q == ADDR);
    assign in_resp = (state_q == RESP);

    always_comb begin
        pick_m1 = ~M0.AW_VALID;
`ifdef AXI_WARB_ROUND_ROBIN_EN
        if (M0.AW_VALID && M1.AW_VALID) begin
            pick_m1 = ~last_grant_q;
        end
`endif
    end

    // Datapath follows the registered grant only, so nothing leaks while idle.
    always_comb begin
        mg_aw_valid = 1'b0;
        mg_w_valid  = 1'b0;
        mg_b_ready  = 1'b0;
        aw_addr_mux = '0;
        w_data_mux  = '0;
        w_strb_mux  = '0;
        if (sel0) begin
            mg_aw_valid = M0.AW_VALID;
            mg_w_valid  = M0.W_VALID;
            mg_b_ready  = M0.B_READY;
            aw_addr_mux = M0.AW_ADDR;
            w_data_mux  = M0.W_DATA;
            w_strb_mux  = M0.W_STRB;
        end else if (sel1) begin
            mg_aw_valid = M1.AW_VALID;
            mg_w_valid  = M1.W_VALID;
            mg_b_ready  = M1.B_READY;
            aw_addr_mux = M1.AW_ADDR;
            w_data_mux  = M1.W_DATA;
            w_strb_mux  = M1.W_STRB;
        end
    end

    assign s_aw_valid = in_addr & mg_aw_valid & ~aw_done_q;
    assign s_w_valid  = in_addr & mg_w_valid & ~w_done_q;
    assign s_b_ready  = in_resp & mg_b_ready;
    assign aw_hs      = s_aw_valid & S.AW_READY;
    assign w_hs       = s_w_valid & S.W_READY;
    assign b_hs       = S.B_VALID & s_b_ready;

    assign S.AW_ADDR  = aw_addr_mux;
    assign S.AW_VALID = s_aw_valid;
    assign S.W_DATA   = w_data_mux;
    assign S.W_STRB   = w_strb_mux;
    assign S.W_VALID  = s_w_valid;
    assign S.B_READY  = s_b_ready;

    assign M0.AW_READY = sel0 & in_addr & S.AW_READY & ~aw_done_q;
    assign M0.W_READY  = sel0 & in_addr & S.W_READY & ~w_done_q;
    assign M0.B_VALID  = sel0 & in_resp & S.B_VALID;
    assign M0.B_RESP   = (sel0 & in_resp) ? S.B_RESP : 2'b00;
    assign M1.AW_READY = sel1 & in_addr & S.AW_READY & ~aw_done_q;
    assign M1.W_READY  = sel1 & in_addr & S.W_READY & ~w_done_q;
    assign M1.B_VALID  = sel1 & in_resp & S.B_VALID;
    assign M1.B_RESP   = (sel1 & in_resp) ? S.B_RESP : 2'b00;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (M0.AW_VALID || M1.AW_VALID) begin
                    grant_d = pick_m1 ? 2'b10 : 2'b01;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                // AW and W may finish in either order or together.
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (b_hs) begin
                    last_grant_d = grant_q[1];
                    grant_d      = 2'b00;
                    state_d      = IDLE;
                end
            end
            default: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            busy_q       <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            busy_q       <= (state_d != IDLE);
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign GRANT = grant_q;
    assign BUSY  = busy_q;
endmodule
